// File: rtl/ifreq_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ifreq_arbiter_pkg
//   Shared types for the IFLogic request / store arbiter.
//   - FTk_t       : forward token (valid, attribute, route flags + payload).
//                   A token with v, a and r all set is the terminal token.
//   - BTk_t       : back token (n = not-granted/back-pressure, t, v, c).
//   - fsm_ifarb_t : arbiter state encoding.
//   - ftk_terminal: helper that recognises the terminal store token.
// ---------------------------------------------------------------------------
package ifreq_arbiter_pkg;

    localparam int FTK_D_W = 16;

    typedef struct packed {
        logic               v;
        logic               a;
        logic               r;
        logic [FTK_D_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_HEADER  = 3'd1,
        ARB_WAIT    = 3'd2,
        ARB_STORE   = 3'd3,
        ARB_RELEASE = 3'd4
    } fsm_ifarb_t;

    // Back token seen by every requester that does not hold the grant.
    localparam BTk_t BTK_NOT_GRANTED = '{n: 1'b1, t: 1'b0, v: 1'b0, c: 1'b0};

    function automatic logic ftk_terminal(input FTk_t tk);
        return tk.v & tk.a & tk.r;
    endfunction

endpackage

// File: rtl/ifreq_arbiter_rrpick.sv
// ---------------------------------------------------------------------------
// ifreq_arbiter_rrpick  (RRPick)
//   Combinational round-robin picker. Returns the first set request bit
//   found scanning upward from i_ptr+1, wrapping modulo NUM_IF, so the
//   requester at i_ptr (the last one served) has lowest priority.
//   Reusable for load-side arbitration.
//
// Ports:
//   i_req  in  NUM_IF  request vector
//   i_ptr  in  IDX_W   index of the previously served requester
//   o_idx  out IDX_W   chosen index (0 when o_any is low)
//   o_any  out 1       at least one request is set
// ---------------------------------------------------------------------------
module ifreq_arbiter_rrpick #(
    parameter  int NUM_IF = 4,
    localparam int IDX_W  = $clog2(NUM_IF)
) (
    input  logic [NUM_IF-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        // Walk offsets from farthest to nearest; the last hit written is the
        // nearest set bit after i_ptr, which is the round-robin winner.
        for (int off = NUM_IF; off >= 1; off--) begin
            for (int j = 0; j < NUM_IF; j++) begin
                if ((j == ((int'(i_ptr) + off) % NUM_IF)) && i_req[j]) begin
                    o_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ifreq_arbiter.sv
// ---------------------------------------------------------------------------
// ifreq_arbiter
//   Shares one IFUnit front-end request channel and one ERAM store port
//   among NUM_IF IFLogic instances. A requester is chosen round-robin, its
//   header stream is forwarded to the front-end, and once the front-end
//   acknowledges the path its store stream is muxed onto the ERAM port
//   until the terminal token has passed.
//
// Parameters:
//   NUM_IF   number of requesters (>= 2)
//   TIMEOUT  cycles allowed waiting for I_Path_Ack; 0 disables the watchdog
//
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   I_Header      per-requester header flag
//   I_Req_FTk     per-requester header token      -> O_Req_FTk (front-end)
//   I_Req_BTk     front-end back token            -> O_Req_BTk (requesters)
//   I_Path_Ack    front-end reports path established
//   O_St          per-requester store enable (registered)
//   I_St_FTk      per-requester store stream      -> O_FTk_IF (ERAM)
//   I_BTk_IF      ERAM back token                 -> O_St_BTk (requesters)
//   O_Grant_V     a grant is held (registered)
//   O_Grant_Id    index of the granted requester (registered)
//   O_Err         one-cycle pulse on watchdog abort (registered)
// ---------------------------------------------------------------------------
module ifreq_arbiter
    import ifreq_arbiter_pkg::*;
#(
    parameter  int NUM_IF  = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDX_W   = $clog2(NUM_IF)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_IF-1:0]    I_Header,
    input  FTk_t [NUM_IF-1:0]    I_Req_FTk,
    output FTk_t                 O_Req_FTk,
    output BTk_t [NUM_IF-1:0]    O_Req_BTk,
    input  BTk_t                 I_Req_BTk,
    input  logic                 I_Path_Ack,
    output logic [NUM_IF-1:0]    O_St,
    input  FTk_t [NUM_IF-1:0]    I_St_FTk,
    output BTk_t [NUM_IF-1:0]    O_St_BTk,
    output FTk_t                 O_FTk_IF,
    input  BTk_t                 I_BTk_IF,
    output logic                 O_Grant_V,
    output logic [IDX_W-1:0]     O_Grant_Id,
    output logic                 O_Err
);

    // Watchdog counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int                WCNT_W    = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam bit                WDOG_EN   = (TIMEOUT != 0);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);

    fsm_ifarb_t          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_g;
    logic [WCNT_W-1:0]   r_wcnt;

    logic [IDX_W-1:0]    w_pick;
    logic                w_any;
    logic                w_hdr_g;
    FTk_t                w_req_ftk_g;
    FTk_t                w_st_ftk_g;
    logic [NUM_IF-1:0]   w_onehot_g;
    logic                w_term_g;

    ifreq_arbiter_rrpick #(
        .NUM_IF (NUM_IF)
    ) u_rrpick (
        .i_req (I_Header),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // Select the granted requester's signals; compared against r_g per lane
    // so non-power-of-two NUM_IF never indexes past the array.
    always_comb begin
        w_hdr_g     = 1'b0;
        w_req_ftk_g = '0;
        w_st_ftk_g  = '0;
        w_onehot_g  = '0;
        for (int k = 0; k < NUM_IF; k++) begin
            if (IDX_W'(k) == r_g) begin
                w_hdr_g       = I_Header[k];
                w_req_ftk_g   = I_Req_FTk[k];
                w_st_ftk_g    = I_St_FTk[k];
                w_onehot_g[k] = 1'b1;
            end
        end
    end

    assign w_term_g  = ftk_terminal(w_st_ftk_g);

    // Forward data paths are purely combinational: no added latency.
    assign O_Req_FTk = (r_state == ARB_HEADER) ? w_req_ftk_g : '0;
    assign O_FTk_IF  = (r_state == ARB_STORE)  ? w_st_ftk_g  : '0;

    always_comb begin
        for (int k = 0; k < NUM_IF; k++) begin
            O_Req_BTk[k] = BTK_NOT_GRANTED;
            O_St_BTk[k]  = '0;
            if ((r_state != ARB_IDLE) && w_onehot_g[k]) begin
                O_Req_BTk[k] = (r_state == ARB_HEADER) ? I_Req_BTk : '0;
                if (r_state == ARB_STORE) begin
                    O_St_BTk[k] = I_BTk_IF;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= IDX_W'(NUM_IF - 1);
            r_g        <= '0;
            r_wcnt     <= '0;
            O_St       <= '0;
            O_Grant_V  <= 1'b0;
            O_Grant_Id <= '0;
            O_Err      <= 1'b0;
        end else begin
            O_Err <= 1'b0;
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_g        <= w_pick;
                        O_Grant_Id <= w_pick;
                        O_Grant_V  <= 1'b1;
                        r_state    <= ARB_HEADER;
                    end
                end
                ARB_HEADER: begin
                    if (!w_hdr_g) begin
                        r_wcnt  <= '0;
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // Ack takes precedence over a coincident timeout.
                    if (I_Path_Ack) begin
                        r_wcnt  <= '0;
                        O_St    <= w_onehot_g;
                        r_state <= ARB_STORE;
                    end else if (WDOG_EN && (r_wcnt == WCNT_LAST)) begin
                        O_Err   <= 1'b1;
                        r_state <= ARB_RELEASE;
                    end else if (r_wcnt != WCNT_MAX) begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ARB_STORE: begin
                    // The terminal token itself is forwarded this cycle.
                    if (w_term_g) begin
                        O_St    <= '0;
                        r_state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    O_St      <= '0;
                    r_wcnt    <= '0;
                    r_ptr     <= r_g;
                    O_Grant_V <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
                default: begin
                    O_St      <= '0;
                    O_Grant_V <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifreq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ifreq_arbiter
//   Directed bench for ifreq_arbiter (NUM_IF=4, TIMEOUT=8). A cycle table
//   drives header/ack/terminal inputs and lists the expected phase, grant
//   id, store enables and error pulse after each clock; the data muxes are
//   checked from that expected phase. Hand sequences cover contention,
//   fairness and reset during a store.
// ---------------------------------------------------------------------------
module tb_ifreq_arbiter;
    import ifreq_arbiter_pkg::*;

    localparam int P_IDLE = 0;
    localparam int P_HDR  = 1;
    localparam int P_WAIT = 2;
    localparam int P_STO  = 3;
    localparam int P_REL  = 4;

    localparam BTk_t NG     = '{n: 1'b1, t: 1'b0, v: 1'b0, c: 1'b0};
    localparam BTk_t REQ_IN = '{n: 1'b0, t: 1'b1, v: 1'b1, c: 1'b0};
    localparam BTk_t IF_IN  = '{n: 1'b0, t: 1'b0, v: 1'b1, c: 1'b1};

    logic          clock;
    logic          reset;
    logic [3:0]    I_Header;
    FTk_t [3:0]    I_Req_FTk;
    FTk_t          O_Req_FTk;
    BTk_t [3:0]    O_Req_BTk;
    BTk_t          I_Req_BTk;
    logic          I_Path_Ack;
    logic [3:0]    O_St;
    FTk_t [3:0]    I_St_FTk;
    BTk_t [3:0]    O_St_BTk;
    FTk_t          O_FTk_IF;
    BTk_t          I_BTk_IF;
    logic          O_Grant_V;
    logic [1:0]    O_Grant_Id;
    logic          O_Err;

    ifreq_arbiter #(
        .NUM_IF  (4),
        .TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .I_Header   (I_Header),
        .I_Req_FTk  (I_Req_FTk),
        .O_Req_FTk  (O_Req_FTk),
        .O_Req_BTk  (O_Req_BTk),
        .I_Req_BTk  (I_Req_BTk),
        .I_Path_Ack (I_Path_Ack),
        .O_St       (O_St),
        .I_St_FTk   (I_St_FTk),
        .O_St_BTk   (O_St_BTk),
        .O_FTk_IF   (O_FTk_IF),
        .I_BTk_IF   (I_BTk_IF),
        .O_Grant_V  (O_Grant_V),
        .O_Grant_Id (O_Grant_Id),
        .O_Err      (O_Err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] hdr;
        logic       ack;
        logic [3:0] term;
        int         ph;
        int         gid;
        logic [3:0] st;
        logic       err;
    } vec_t;

    vec_t       tbl[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] cur_hdr;
    logic       cur_ack;
    logic [3:0] cur_term;

    function automatic FTk_t req_tok(input int k);
        FTk_t t;
        t.v = 1'b1;
        t.a = 1'b0;
        t.r = 1'b0;
        t.d = FTK_D_W'(32'hA000 + k);
        return t;
    endfunction

    function automatic FTk_t st_tok(input int k, input logic term);
        FTk_t t;
        t.v = 1'b1;
        t.a = term;
        t.r = term;
        t.d = FTK_D_W'(32'h5000 + k);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply();
        I_Header   = cur_hdr;
        I_Path_Ack = cur_ack;
        for (int k = 0; k < 4; k++) begin
            I_Req_FTk[k] = req_tok(k);
            I_St_FTk[k]  = st_tok(k, cur_term[k]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [3:0] h, input logic a, input logic [3:0] t,
                       input int ph, input int gid, input logic [3:0] st, input logic err);
        vec_t v;
        v.hdr = h; v.ack = a; v.term = t; v.ph = ph; v.gid = gid; v.st = st; v.err = err;
        tbl.push_back(v);
    endtask

    // Data-path expectations derived from the phase the arbiter should be in.
    task automatic chk_data(input string tag, input int ph, input int gid);
        FTk_t       e_rftk;
        FTk_t       e_ftk;
        BTk_t [3:0] e_rbtk;
        BTk_t [3:0] e_sbtk;
        e_rftk = (ph == P_HDR) ? req_tok(gid) : '0;
        e_ftk  = (ph == P_STO) ? st_tok(gid, cur_term[gid[1:0]]) : '0;
        for (int k = 0; k < 4; k++) begin
            e_rbtk[k] = NG;
            e_sbtk[k] = '0;
            if ((ph != P_IDLE) && (k == gid)) begin
                e_rbtk[k] = (ph == P_HDR) ? REQ_IN : '0;
                e_sbtk[k] = (ph == P_STO) ? IF_IN : '0;
            end
        end
        chk({tag, "_req_ftk"}, 64'(O_Req_FTk), 64'(e_rftk));
        chk({tag, "_ftk_if"},  64'(O_FTk_IF),  64'(e_ftk));
        chk({tag, "_req_btk"}, 64'(O_Req_BTk), 64'(e_rbtk));
        chk({tag, "_st_btk"},  64'(O_St_BTk),  64'(e_sbtk));
    endtask

    task automatic do_reset();
        cur_hdr  = '0;
        cur_ack  = 1'b0;
        cur_term = '0;
        apply();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One complete grant: wait for it, drop header, ack, terminal, release.
    task automatic run_grant(input string tag, input int exp_id, input bit rereq);
        int         w;
        BTk_t [3:0] e_btk;
        logic [3:0] e_st;
        w = 0;
        while (!O_Grant_V && w < 6) begin
            tick();
            w++;
        end
        chk({tag, "_gv"}, 64'(O_Grant_V), 64'(1));
        chk({tag, "_gid"}, 64'(O_Grant_Id), 64'(exp_id));
        e_st = '0;
        for (int k = 0; k < 4; k++) begin
            e_btk[k] = (k == exp_id) ? REQ_IN : NG;
            e_st[k]  = (k == exp_id);
        end
        chk({tag, "_hdr_btk"}, 64'(O_Req_BTk), 64'(e_btk));
        chk({tag, "_hdr_ftk"}, 64'(O_Req_FTk), 64'(req_tok(exp_id)));
        for (int k = 0; k < 4; k++) if (k == exp_id) cur_hdr[k] = 1'b0;
        apply();
        tick();
        cur_ack = 1'b1;
        apply();
        tick();
        cur_ack = 1'b0;
        apply();
        chk({tag, "_st"}, 64'(O_St), 64'(e_st));
        for (int k = 0; k < 4; k++) if (k == exp_id) e_btk[k] = '0;
        chk({tag, "_st_req_btk"}, 64'(O_Req_BTk), 64'(e_btk));
        for (int k = 0; k < 4; k++) if (k == exp_id) cur_term[k] = 1'b1;
        apply();
        #1;
        chk({tag, "_term_fwd"}, 64'(O_FTk_IF), 64'(st_tok(exp_id, 1'b1)));
        tick();
        cur_term = '0;
        apply();
        chk({tag, "_st_drop"}, 64'(O_St), 64'(0));
        chk({tag, "_rel_gv"}, 64'(O_Grant_V), 64'(1));
        if (rereq) begin
            for (int k = 0; k < 4; k++) if (k == exp_id) cur_hdr[k] = 1'b1;
            apply();
        end
        tick();
        chk({tag, "_idle_gv"}, 64'(O_Grant_V), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        I_Req_BTk = REQ_IN;
        I_BTk_IF  = IF_IN;
        reset     = 1'b1;
        cur_hdr   = '0;
        cur_ack   = 1'b0;
        cur_term  = '0;
        apply();
        #1;
        chk("rst_st",  64'(O_St),       64'(0));
        chk("rst_gv",  64'(O_Grant_V),  64'(0));
        chk("rst_gid", 64'(O_Grant_Id), 64'(0));
        chk("rst_err", 64'(O_Err),      64'(0));
        chk_data("rst", P_IDLE, 0);

        // Single requester 2: header 5 cycles, ack 3 cycles after drop,
        // store enable high for 11 cycles.
        repeat (5) add(4'b0100, 1'b0, 4'b0000, P_HDR,  2, 4'b0000, 1'b0);
        repeat (3) add(4'b0000, 1'b0, 4'b0000, P_WAIT, 2, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, P_STO, 2, 4'b0100, 1'b0);
        repeat (10) add(4'b0000, 1'b0, 4'b0000, P_STO, 2, 4'b0100, 1'b0);
        add(4'b0000, 1'b0, 4'b0100, P_REL,  2, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, P_IDLE, 2, 4'b0000, 1'b0);
        // ptr is now 2, so requester 3 wins over 0,1,2.
        add(4'b1111, 1'b0, 4'b0000, P_HDR,  3, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, P_WAIT, 3, 4'b0000, 1'b0);
        // Watchdog: no ack, error pulse 8 cycles after entering the wait.
        repeat (7) add(4'b0000, 1'b0, 4'b0000, P_WAIT, 3, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, P_REL,  3, 4'b0000, 1'b1);
        add(4'b0011, 1'b0, 4'b0000, P_IDLE, 3, 4'b0000, 1'b0);
        add(4'b0011, 1'b0, 4'b0000, P_HDR,  0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, P_WAIT, 0, 4'b0000, 1'b0);
        // Ack arrives on the very cycle the watchdog would expire.
        repeat (7) add(4'b0000, 1'b0, 4'b0000, P_WAIT, 0, 4'b0000, 1'b0);
        add(4'b0000, 1'b1, 4'b0000, P_STO,  0, 4'b0001, 1'b0);
        add(4'b0000, 1'b0, 4'b0001, P_REL,  0, 4'b0000, 1'b0);
        add(4'b0000, 1'b0, 4'b0000, P_IDLE, 0, 4'b0000, 1'b0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag      = $sformatf("row%0d", i);
            cur_hdr  = tbl[i].hdr;
            cur_ack  = tbl[i].ack;
            cur_term = tbl[i].term;
            apply();
            tick();
            chk({tag, "_gv"},  64'(O_Grant_V),  64'(tbl[i].ph != P_IDLE));
            chk({tag, "_gid"}, 64'(O_Grant_Id), 64'(tbl[i].gid));
            chk({tag, "_st"},  64'(O_St),       64'(tbl[i].st));
            chk({tag, "_err"}, 64'(O_Err),      64'(tbl[i].err));
            chk_data(tag, tbl[i].ph, tbl[i].gid);
        end

        // Contention from reset: 0, 1, 3.
        do_reset();
        cur_hdr = 4'b1011;
        apply();
        run_grant("cont0", 0, 1'b0);
        run_grant("cont1", 1, 1'b0);
        run_grant("cont3", 3, 1'b0);

        // Fairness: 0 and 1 keep re-requesting -> 0, 1, 0, 1.
        cur_hdr = 4'b0011;
        apply();
        run_grant("fair0a", 0, 1'b1);
        run_grant("fair1a", 1, 1'b1);
        run_grant("fair0b", 0, 1'b1);
        run_grant("fair1b", 1, 1'b0);
        cur_hdr = '0;
        apply();
        tick();

        // Reset in the middle of a store.
        do_reset();
        cur_hdr = 4'b0100;
        apply();
        tick();
        chk("mr_gid", 64'(O_Grant_Id), 64'(2));
        cur_hdr = '0;
        apply();
        tick();
        cur_ack = 1'b1;
        apply();
        tick();
        cur_ack = 1'b0;
        apply();
        chk("mr_st_on", 64'(O_St), 64'(4'b0100));
        #2;
        reset = 1'b1;
        #1;
        chk("mr_st_off", 64'(O_St),      64'(0));
        chk("mr_ftk_if", 64'(O_FTk_IF),  64'(0));
        chk("mr_gv",     64'(O_Grant_V), 64'(0));
        @(posedge clock);
        #1;
        reset   = 1'b0;
        cur_hdr = 4'b1111;
        apply();
        tick();
        chk("mr_prio_gv",  64'(O_Grant_V),  64'(1));
        chk("mr_prio_gid", 64'(O_Grant_Id), 64'(0));
        cur_hdr = '0;
        apply();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
